// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants, state type and grant encoding for the 4-way arbiter
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search starting at ptr
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest hit is written last.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin owner of a shared 4:1 datapath with burst capping
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]          sel,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic               beat;
  logic               burst_done;
  logic               release_now;
  logic [NUM_REQ-1:0] pick_req;
  logic [SEL_W-1:0]   pick_ptr;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  sel_data;

  assign busy        = (state == GRANT);
  assign out_valid   = (state == GRANT) && req[sel] && !rst;
  assign beat        = out_valid && out_ready;
  assign burst_done  = beat && (beat_cnt == LAST_BEAT);
  assign release_now = (state == GRANT) && (!req[sel] || burst_done);

  // A winner that filled its burst may win again, but only behind everyone else via the new ptr.
  assign pick_req = (state == IDLE) ? req : (burst_done ? req : (req & ~gnt));
  assign pick_ptr = (state == IDLE) ? ptr : sel + SEL_W'(1);

  rr_pick u_rr_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == SEL_W'(i)) sel_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign out_data = out_valid ? sel_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt      <= onehot4(pick_idx);
            sel      <= pick_idx;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr      <= pick_ptr;
            beat_cnt <= '0;
            if (pick_any) begin
              gnt <= onehot4(pick_idx);
              sel <= pick_idx;
            end else begin
              gnt   <= '0;
              state <= IDLE;
            end
          end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed bench with a cycle-level arbitration model
module tb_mux4_rr_arbiter;

  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [3:0]          req = 4'b1111;
  logic [4*DATA_W-1:0] in_data;
  logic                out_ready = 1'b1;
  logic [3:0]          gnt;
  logic [1:0]          sel;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int m_cur = -1;
  int m_sel = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  int lane_cnt[4] = '{0, 0, 0, 0};

  mux4_rr_arbiter #(
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] lane_word(input int i);
    return DATA_W'(i * 64 + lane_cnt[i]);
  endfunction

  function automatic int rr_search(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < 4; i++) in_data[i*DATA_W +: DATA_W] = lane_word(i);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Arbitration rules applied to the inputs seen at each rising edge.
  always @(posedge clk) begin : model
    bit v, b, full;
    logic [3:0] cands;
    int nxt;
    if (rst) begin
      m_cur = -1; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_cur < 0) begin
      nxt = rr_search(req, m_ptr);
      if (nxt >= 0) begin
        m_cur = nxt; m_sel = nxt; m_cnt = 0;
      end
    end else begin
      v    = req[m_cur];
      b    = v && out_ready;
      full = b && (m_cnt == MAX_BURST - 1);
      if (b) lane_cnt[m_cur]++;
      if (!v || full) begin
        m_ptr = (m_cur + 1) % 4;
        cands = req;
        if (!full) cands[m_cur] = 1'b0;
        nxt = rr_search(cands, m_ptr);
        if (nxt >= 0) begin
          m_cur = nxt; m_sel = nxt;
        end else begin
          m_cur = -1;
        end
        m_cnt = 0;
      end else if (b) begin
        m_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    drive_data();
  end

  always @(negedge clk) begin : compare
    logic [3:0] eg;
    logic ev;
    logic [DATA_W-1:0] ed;
    if (chk_en) begin
      eg = '0;
      ev = 1'b0;
      if (m_cur >= 0) begin
        eg = 4'(1 << m_cur);
        ev = req[m_cur] && !rst;
      end
      ed = ev ? lane_word(m_cur) : '0;
      chk("cyc_gnt", 32'(gnt), 32'(eg));
      chk("cyc_sel", 32'(sel), 32'(m_sel));
      chk("cyc_valid", 32'(out_valid), 32'(ev));
      chk("cyc_data", 32'(out_data), 32'(ed));
      chk("cyc_busy", 32'(busy), 32'(m_cur >= 0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    drive_data();
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("rot_gnt", 32'(gnt), 32'(1 << ((k / 4) % 4)));
    end
    tick();
    req = 4'b0000;
    tick();
    @(negedge clk);
    chk("drain_gnt", 32'(gnt), 32'h0);

    req = 4'b0100;
    tick();
    @(negedge clk);
    chk("early_gnt", 32'(gnt), 32'h4);
    chk("early_sel", 32'(sel), 32'h2);
    tick();
    tick();
    req = 4'b0000;
    @(negedge clk);
    chk("early_novalid", 32'(out_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("early_idle", 32'(gnt), 32'h0);
    chk("early_ptr", 32'(dut.ptr), 32'h3);
    req = 4'b0101;
    tick();
    @(negedge clk);
    chk("after_early_gnt", 32'(gnt), 32'h1);

    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_gnt", 32'(gnt), 32'h1);
      chk("stall_sel", 32'(sel), 32'h0);
      chk("stall_cnt", 32'(dut.beat_cnt), 32'h2);
      chk("stall_valid", 32'(out_valid), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("resume_cnt", 32'(dut.beat_cnt), 32'h2);
    tick();
    @(negedge clk);
    chk("resume_gnt", 32'(gnt), 32'h1);
    chk("resume_cnt3", 32'(dut.beat_cnt), 32'h3);
    tick();
    @(negedge clk);
    chk("bp_next_gnt", 32'(gnt), 32'h4);

    req = 4'b1000;
    tick();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("sole_gnt", 32'(gnt), 32'h8);
      chk("sole_cnt", 32'(dut.beat_cnt), 32'(k % 4));
      tick();
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0110;
    @(negedge clk);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_ptr", 32'(dut.ptr), 32'h0);
    tick();
    @(negedge clk);
    chk("midrst_next_gnt", 32'(gnt), 32'h2);
    tick();
    tick();
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
